// File: rtl/uart_tx_frame_packer.sv
// uart_tx_frame_packer: packs AXIS bytes LSB-first into FRAME_WIDTH-bit frames queued in a FWFT FIFO.
// Define TX_PACK_TLAST_EN to add s_axis_tlast, which flushes a zero-filled partial frame.
module uart_tx_frame_packer #(
    parameter int FRAME_WIDTH = 64,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
`ifdef TX_PACK_TLAST_EN
    input  logic                        s_axis_tlast,
`endif
    output logic [FRAME_WIDTH-1:0]      m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int N     = FRAME_WIDTH / 8;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    logic [FRAME_WIDTH-1:0] pack_q, pack_d;
    logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic [FRAME_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [FRAME_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;

    logic                   last_byte;
    logic                   flush;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   in_xfer;
    logic                   push;
    logic                   pop;
    logic [FRAME_WIDTH-1:0] frame_data;

    // Handshake decode; tready depends only on registered state (and tlast), never on m_axis_tready.
    always_comb begin
        last_byte = (byte_cnt_q == LAST_CNT);
`ifdef TX_PACK_TLAST_EN
        flush     = last_byte || s_axis_tlast;
`else
        flush     = last_byte;
`endif
        fifo_full     = (level_q == FULL_LVL);
        fifo_empty    = (level_q == '0);
        s_axis_tready = !(flush && fifo_full);
        in_xfer       = s_axis_tvalid && s_axis_tready;
        push          = in_xfer && flush;
        pop           = !fifo_empty && m_axis_tready;
        // Slots above byte_cnt are already zero, so this also zero-fills a flushed partial frame.
        frame_data    = pack_q | (FRAME_WIDTH'(s_axis_tdata) << {byte_cnt_q, 3'b000});
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        pack_d     = pack_q;
        byte_cnt_d = byte_cnt_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;

        if (in_xfer) begin
            if (push) begin
                pack_d     = '0;
                byte_cnt_d = '0;
            end else begin
                pack_d     = frame_data;
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
            end
        end

        if (push) begin
            mem_d[wr_ptr_q] = frame_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // NOTE: the frame storage is reset too, so m_axis_tdata reads a defined 0 out of reset.
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q     <= '0;
            byte_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            pack_q     <= pack_d;
            byte_cnt_q <= byte_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            mem_q      <= mem_d;
        end
    end

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = mem_q[rd_ptr_q];
    assign fifo_level    = level_q;

endmodule
